// File: rtl/axis_mv_pkg.sv
`default_nettype none
// ============================================================================
// axis_mv_pkg : shared types, width helpers and output reduction for axis_affine_mv
// Macro: AXIS_MV_SATURATE_EN selects clamping instead of two's-complement wrap.
// Rev 1.0
// ============================================================================
package axis_mv_pkg;

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } mv_state_e;

  localparam int RED_W = 64;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Wide enough that a full LANES-term sum of products never overflows.
  function automatic int acc_w(input int data_width, input int lanes);
    return 2 * data_width + clog2_f(lanes);
  endfunction

`ifdef AXIS_MV_SATURATE_EN
  function automatic logic signed [RED_W-1:0] reduce_out(input logic signed [RED_W-1:0] v,
                                                         input int out_w);
    logic signed [RED_W-1:0] hi;
    logic signed [RED_W-1:0] lo;
    hi = (RED_W'(1) <<< (out_w - 1)) - RED_W'(1);
    lo = -(RED_W'(1) <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
`else
  function automatic logic signed [RED_W-1:0] reduce_out(input logic signed [RED_W-1:0] v,
                                                         input int out_w);
    return (v <<< (RED_W - out_w)) >>> (RED_W - out_w);
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/axis_mv_row_dot.sv
`default_nettype none
// ============================================================================
// axis_mv_row_dot : one matrix row times vector, registered products then
// combinational sum, floor shift and reduction to OUT_WIDTH.
// Rev 1.0
// ============================================================================
module axis_mv_row_dot
  import axis_mv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int LANES      = 4,
  parameter int FRAC_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [LANES*DATA_WIDTH-1:0]   coef,
  input  logic [LANES*DATA_WIDTH-1:0]   vec,
  output logic [OUT_WIDTH-1:0]          y
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = acc_w(DATA_WIDTH, LANES);

  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;

  always_comb begin
    for (int c = 0; c < LANES; c++) begin
      prod_d[c] = PROD_W'($signed(coef[c*DATA_WIDTH +: DATA_WIDTH]))
                * PROD_W'($signed(vec[c*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < LANES; c++) prod_q[c] <= '0;
    end else if (en) begin
      prod_q <= prod_d;
    end
  end

  always_comb begin
    acc = '0;
    for (int c = 0; c < LANES; c++) acc = acc + ACC_W'(prod_q[c]);
    shifted = acc >>> FRAC_BITS;
    y       = OUT_WIDTH'(reduce_out(RED_W'(shifted), OUT_WIDTH));
  end

endmodule
`default_nettype wire

// File: rtl/axis_affine_mv.sv
`default_nettype none
// ============================================================================
// axis_affine_mv : AXI4-Stream affine matrix-vector engine; ROWS coefficient
// beats per frame, then one output per vector. Macro: AXIS_MV_SATURATE_EN.
// Rev 1.0
// ============================================================================
module axis_affine_mv
  import axis_mv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int LANES      = 4,
  parameter int ROWS       = 3,
  parameter int FRAC_BITS  = 8
) (
  input  logic                        s00_axis_aclk,
  input  logic                        s00_axis_aresetn,
  input  logic [LANES*DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                        s00_axis_tvalid,
  output logic                        s00_axis_tready,
  input  logic                        s00_axis_tlast,
  output logic [LANES*OUT_WIDTH-1:0]  m00_axis_tdata,
  output logic                        m00_axis_tvalid,
  input  logic                        m00_axis_tready,
  output logic                        m00_axis_tlast
);

  localparam int ROW_CNT_W = (ROWS > 1) ? clog2_f(ROWS) : 1;

  mv_state_e                   state_q, state_d;
  logic [ROW_CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic [LANES*DATA_WIDTH-1:0] mat_q [ROWS];
  logic [LANES*DATA_WIDTH-1:0] mat_d [ROWS];
  logic                        in_valid_q, in_valid_d, in_last_q, in_last_d;
  logic [LANES*DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic                        prod_valid_q, prod_valid_d, prod_last_q, prod_last_d;
  logic                        tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [LANES*OUT_WIDTH-1:0]  tdata_q, tdata_d;
  logic [OUT_WIDTH-1:0]        lane_out [LANES];
  logic                        en, accept, load_we, vec_we;

  // One stall signal freezes every stage; no skid buffer upstream.
  assign en     = !tvalid_q || m00_axis_tready;
  assign accept = s00_axis_tvalid && en;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    if (accept) begin
      unique case (state_q)
        LOAD: begin
          if (row_cnt_q == ROW_CNT_W'(ROWS - 1)) begin
            state_d   = STREAM;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
        STREAM: if (s00_axis_tlast) state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin
    s00_axis_tready = en;
    load_we         = accept && (state_q == LOAD);
    vec_we          = accept && (state_q == STREAM);
  end

  always_comb begin
    mat_d = mat_q;
    if (load_we) mat_d[row_cnt_q] = s00_axis_tdata;

    in_valid_d   = in_valid_q;
    in_last_d    = in_last_q;
    in_data_d    = in_data_q;
    prod_valid_d = prod_valid_q;
    prod_last_d  = prod_last_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    if (en) begin
      in_valid_d   = vec_we;
      in_last_d    = s00_axis_tlast;
      in_data_d    = s00_axis_tdata;
      prod_valid_d = in_valid_q;
      prod_last_d  = in_last_q;
      tvalid_d     = prod_valid_q;
      tlast_d      = prod_last_q;
      for (int r = 0; r < LANES; r++) tdata_d[r*OUT_WIDTH +: OUT_WIDTH] = lane_out[r];
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      for (int r = 0; r < ROWS; r++) mat_q[r] <= '0;
      in_valid_q   <= 1'b0;
      in_last_q    <= 1'b0;
      in_data_q    <= '0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      mat_q        <= mat_d;
      in_valid_q   <= in_valid_d;
      in_last_q    <= in_last_d;
      in_data_q    <= in_data_d;
      prod_valid_q <= prod_valid_d;
      prod_last_q  <= prod_last_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
    end
  end

  for (genvar r = 0; r < LANES; r++) begin : g_lane
    if (r < ROWS) begin : g_row
      axis_mv_row_dot #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .LANES      (LANES),
        .FRAC_BITS  (FRAC_BITS)
      ) u_row_dot (
        .clk   (s00_axis_aclk),
        .rst_n (s00_axis_aresetn),
        .en    (en),
        .coef  (mat_q[r]),
        .vec   (in_data_q),
        .y     (lane_out[r])
      );
    end else begin : g_pass
      // Delay slot matching the product stage so pass-through lanes stay aligned.
      logic signed [DATA_WIDTH-1:0] pass_q, pass_d;
      always_comb pass_d = en ? in_data_q[r*DATA_WIDTH +: DATA_WIDTH] : pass_q;
      always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) pass_q <= '0;
        else                   pass_q <= pass_d;
      end
      assign lane_out[r] = OUT_WIDTH'(pass_q);
    end
  end

  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;

endmodule
`default_nettype wire
